// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
// Instruction-fetch stage of the MIPS datapath. Owns the program counter,
// issues one word fetch per cycle to instruction memory (same-cycle ready
// response), and registers {instr, pc, pc+4} into the IF/ID slot for decode.
// A redirect (branch/jump target) reloads the PC and flushes the slot; a stall
// freezes the PC and the slot.
//
// Parameters
//   RESET_PC        PC loaded on reset (low two bits are ignored)
//   PC_STEP         increment applied after each accepted fetch
//
// Ports
//   clk             single clock, all state on rising edge
//   rst_n           asynchronous active-low reset
//   stall           freeze PC and IF/ID slot
//   redirect_valid  load redirect_pc and flush the slot (highest priority)
//   redirect_pc     branch/jump target, word aligned internally
//   imem_req        fetch request (combinational)
//   imem_addr       fetch address = pc (combinational)
//   imem_ready      memory returns imem_rdata this cycle
//   imem_rdata      instruction word
//   id_ready        decode consumes the IF/ID slot this cycle
//   if_valid        IF/ID slot holds a valid instruction
//   if_instr        fetched instruction
//   if_pc           address of if_instr
//   if_pc_plus4     if_pc + PC_STEP, modulo 2^32
// -----------------------------------------------------------------------------
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};
  localparam logic [XLEN-1:0] STEP             = XLEN'(PC_STEP);

  typedef enum logic {
    ST_BOOT  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic              r_if_valid;
  logic [XLEN-1:0]   r_if_instr;
  logic [XLEN-1:0]   r_if_pc;
  logic [XLEN-1:0]   r_if_pc_plus4;

  logic              w_slot_free;
  logic              w_req;
  logic              w_accept;
  logic              w_drain;
  logic [XLEN-1:0]   w_pc_inc;
  logic [XLEN-1:0]   w_redirect_aligned;
  logic              w_unused_bits;

  // Low target bits are discarded by word alignment.
  assign w_unused_bits = ^redirect_pc[1:0];

  // Handshake and datapath helpers.
  assign w_slot_free        = !r_if_valid || id_ready;
  assign w_req              = (r_state == ST_FETCH) && !stall && !redirect_valid && w_slot_free;
  assign w_accept           = w_req && imem_ready;
  // Slot empties when decode takes it and nothing refills it; a stall blocks this.
  assign w_drain            = r_if_valid && id_ready && !w_accept && !stall;
  assign w_pc_inc           = r_pc + STEP;
  assign w_redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  // BOOT lasts exactly one clock after reset release; FETCH is terminal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= ST_FETCH;
    end
  end

  // Program counter: redirect beats everything, otherwise advance on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC_ALIGNED;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_aligned;
    end else if (w_accept) begin
      r_pc <= w_pc_inc;
    end
  end

  // Slot valid: flush on redirect, hold on stall, fill on accept, clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
    end else if (redirect_valid) begin
      r_if_valid <= 1'b0;
    end else if (w_accept) begin
      r_if_valid <= 1'b1;
    end else if (w_drain) begin
      r_if_valid <= 1'b0;
    end
  end

  // Slot payload only changes on an accepted fetch; a redirect discards the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
    end else if (w_accept) begin
      r_if_instr    <= imem_rdata;
      r_if_pc       <= r_pc;
      r_if_pc_plus4 <= w_pc_inc;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int checks;
  int failures;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  // Memory model: every word reads back as its address XOR a key.
  assign imem_rdata = imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic [31:0] pc_e);
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_pc"}, if_pc, pc_e);
    chk({tag, "_instr"}, if_instr, pc_e ^ KEY);
    chk({tag, "_plus4"}, if_pc_plus4, pc_e + 32'd4);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_ready = 1'b1;
    id_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_plus4", if_pc_plus4, 32'h0);

    // Release between edges; BOOT still has imem_req=0
    #10; // t=12
    rst_n = 1'b1;
    #1;
    chk("boot_req", 32'(imem_req), 32'd0);
    step(); // t=16, now FETCH
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr0", imem_addr, 32'h0);
    chk("fetch_valid0", 32'(if_valid), 32'd0);

    // Streaming: one instruction per clock
    for (int k = 0; k < 4; k++) begin
      step();
      chk_slot("stream", 32'(4 * k));
      chk("stream_addr", imem_addr, 32'(4 * k + 4));
      chk("stream_req", 32'(imem_req), 32'd1);
    end

    // Decode back-pressure for 3 clocks
    id_ready = 1'b0;
    #1;
    chk("bp_req", 32'(imem_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_slot("bp_hold", 32'd12);
      chk("bp_addr", imem_addr, 32'd16);
      chk("bp_req_hold", 32'(imem_req), 32'd0);
    end
    id_ready = 1'b1;
    #1;
    chk("bp_resume_req", 32'(imem_req), 32'd1);
    step();
    chk_slot("bp_resume", 32'd16);
    chk("bp_resume_addr", imem_addr, 32'd20);

    // Drain: memory not ready, decode consumes the slot
    imem_ready = 1'b0;
    step();
    chk("drain_valid", 32'(if_valid), 32'd0);
    chk("drain_pc_hold", if_pc, 32'd16);
    chk("drain_addr", imem_addr, 32'd20);
    chk("drain_req", 32'(imem_req), 32'd1);

    // Redirect with same-cycle response: response dropped, target aligned
    imem_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0040_0023;
    #1;
    chk("redir_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(if_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h0040_0020);
    chk("redir_pc_hold", if_pc, 32'd16);
    step();
    chk_slot("redir_fetch", 32'h0040_0020);
    chk("redir_next_addr", imem_addr, 32'h0040_0024);

    // Stall together with redirect: redirect wins
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1000;
    step();
    redirect_valid = 1'b0;
    chk("stallredir_valid", 32'(if_valid), 32'd0);
    chk("stallredir_addr", imem_addr, 32'h0000_1000);
    chk("stallredir_req", 32'(imem_req), 32'd0);
    stall = 1'b0;
    step();
    chk_slot("post_redir", 32'h0000_1000);

    // Stall alone for 2 clocks: everything frozen even with id_ready=1
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_slot("stall_hold", 32'h0000_1000);
      chk("stall_addr", imem_addr, 32'h0000_1004);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;

    // Wrap-around at top of address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", if_pc_plus4, 32'h0);
    chk("wrap_instr", if_instr, 32'h5A5A_5A59);
    chk("wrap_addr", imem_addr, 32'h0);
    step();
    chk_slot("wrap_next", 32'h0);
    chk("wrap_next_addr", imem_addr, 32'd4);

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_pc", if_pc, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("arst_boot_req", 32'(imem_req), 32'd0);
    step();
    chk("arst_fetch_req", 32'(imem_req), 32'd1);
    chk("arst_fetch_addr", imem_addr, 32'h0);
    step();
    chk_slot("arst_first", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
